btn_debounce_multi: RTL and testbench
=====================================

Name: btn_debounce_multi

Overview:
Parametrised multi-channel button cleaner; successor to the single-channel cleaner.
- Each channel synchronises its raw input, qualifies rising and falling edges with a debounce timer, and exposes a debounced level plus one-cycle press and release pulses.
- Sits between the board push-buttons or switches and the control FSMs; one instance serves the whole button bank.

Parameters:
- CHANNELS, 4, number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 4095, timer length in clocks before re-sampling (>=2). Counter width is a localparam: $clog2(DEBOUNCE_CYCLES).
- LONG_CYCLES, 50000000, hold time in clocks for the long-press pulse (>=2). Only used when LONG_PRESS_EN is defined.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- raw  input  CHANNELS  unsynchronised button inputs, bit i = channel i.
- level  output  CHANNELS  debounced button level.
- press  output  CHANNELS  one-cycle pulse on qualified press.
- release  output  CHANNELS  one-cycle pulse on qualified release.
- any_press  output  1  OR of press, registered with press (same cycle).
- long_press  output  CHANNELS  one-cycle pulse after sustained hold; constant 0 without LONG_PRESS_EN.

Behaviour:
- Reset: sync flops 0, every channel in IDLE, counters 0. All outputs (level, press, release, any_press, long_press) are 0 while reset is high and on the first cycle after release.
- Synchroniser: two flops per channel; raw_s = raw delayed 2 edges.
- Per-channel FSM, 4 states, all outputs registered:
  - IDLE (level=0): raw_s=1 -> ARM_P, count<=0.
  - ARM_P (level=0): count increments each cycle. Glitches on raw_s are ignored while counting. At count==DEBOUNCE_CYCLES-1, sample raw_s:
    - 1 -> PRESSED, press pulses.
    - 0 -> IDLE, no pulse.
  - PRESSED (level=1): raw_s=0 -> ARM_R, count<=0.
  - ARM_R (level=1): count increments. At count==DEBOUNCE_CYCLES-1, sample raw_s:
    - 0 -> IDLE, level<=0, release pulses.
    - 1 -> PRESSED, no pulse.
- Latency: if raw is first sampled high at edge E0 and held, press and level go high after edge E0+DEBOUNCE_CYCLES+2. Release is symmetric.
- press and release are high for exactly one cycle per qualified transition. Holding the button never repeats press.
- Channels are fully independent. Simultaneous qualifications on several channels give simultaneous pulses; any_press is high once for that cycle.
- Reset asserted mid-count or mid-hold: immediate return to IDLE. No pulse is emitted on reset entry or exit.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.

Optional Feature:
LONG_PRESS_EN
- Defined:
  - Per-channel hold counter of width $clog2(LONG_CYCLES). It counts while in PRESSED or ARM_R and clears on entering IDLE.
  - When it reaches LONG_CYCLES-1, long_press pulses for one cycle, then the counter saturates. Only one long_press per hold.
  - A bounce back from ARM_R to PRESSED does not restart the hold count.
- Undefined: no hold counters are synthesised; long_press is tied to 0.

Test Plan:
Bench settings: CHANNELS=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
1. Clean press: raw[0] 0->1 sampled at edge 10, held 40 cycles -> level[0] and press[0] high after edge 16; press[0] low after edge 17; any_press mirrors press[0]; other channels stay 0.
2. Glitch rejection: raw[1] high for 2 cycles then low -> ARM_P samples 0, returns to IDLE; level[1], press[1] and release[1] never assert.
3. Bounce during count: raw[2] toggles 1,0,1,1,1 then holds -> exactly one press[2] pulse, 6 edges after the first high sample. Release after a 20-cycle hold -> exactly one release[2] pulse, level[2] low the same cycle.
4. Simultaneous channels: raw[3:0] 0000->1111 on one edge -> press=1111 for one cycle, any_press single pulse, level=1111 after 6 edges.
5. Reset mid-operation: assert reset 2 cycles into ARM_P on channel 0 -> all outputs 0 immediately, no press after reset deasserts while raw stays low. Re-press then qualifies normally.
6. LONG_PRESS_EN defined: hold raw[0] for 40 cycles -> long_press[0] pulses once, 16 cycles after press[0]. Undefined: long_press stays 0.

Source files
------------

// File: rtl/btn_debounce_multi.sv
// Multi-channel button debouncer: 2-flop sync, per-channel qualify FSM, press/release pulses.
// Optional long-press pulse per channel when LONG_PRESS_EN is defined.
module btn_debounce_multi #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4095,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                any_press,
    output logic [CHANNELS-1:0] long_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM_P   = 2'd1;
    localparam logic [1:0] PRESSED = 2'd2;
    localparam logic [1:0] ARM_R   = 2'd3;

    if (CHANNELS < 1 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
        $error("btn_debounce_multi: illegal parameter value");
    end

    logic [CHANNELS-1:0] sync1_q, raw_s_q;
    logic [1:0]          state_q [CHANNELS];
    logic [1:0]          state_d [CHANNELS];
    logic [CNT_W-1:0]    count_q [CHANNELS];
    logic [CNT_W-1:0]    count_d [CHANNELS];
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] rel_q, rel_d;
    logic                any_q;

    always_comb begin
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            case (state_q[i])
                IDLE: begin
                    if (raw_s_q[i]) begin
                        state_d[i] = ARM_P;
                        count_d[i] = '0;
                    end
                end
                ARM_P: begin
                    // Input is only looked at once the timer expires; bounces are ignored.
                    if (count_q[i] == CNT_MAX) begin
                        count_d[i] = '0;
                        if (raw_s_q[i]) begin
                            state_d[i] = PRESSED;
                            level_d[i] = 1'b1;
                            press_d[i] = 1'b1;
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end else begin
                        count_d[i] = count_q[i] + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!raw_s_q[i]) begin
                        state_d[i] = ARM_R;
                        count_d[i] = '0;
                    end
                end
                ARM_R: begin
                    if (count_q[i] == CNT_MAX) begin
                        count_d[i] = '0;
                        if (!raw_s_q[i]) begin
                            state_d[i] = IDLE;
                            level_d[i] = 1'b0;
                            rel_d[i]   = 1'b1;
                        end else begin
                            state_d[i] = PRESSED;
                        end
                    end else begin
                        count_d[i] = count_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    count_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            raw_s_q <= '0;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE;
                count_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            raw_s_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            any_q   <= |press_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = rel_q;
    assign any_press     = any_q;

`ifdef LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0]   hold_q [CHANNELS];
    logic [HOLD_W-1:0]   hold_d [CHANNELS];
    logic [CHANNELS-1:0] fired_q, fired_d;
    logic [CHANNELS-1:0] long_q, long_d;

    always_comb begin
        fired_d = fired_q;
        long_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hold_d[i] = hold_q[i];
            if (state_d[i] == IDLE) begin
                hold_d[i]  = '0;
                fired_d[i] = 1'b0;
            end else if (state_q[i] == PRESSED || state_q[i] == ARM_R) begin
                // Saturate at the top; fired_q limits the pulse to one per hold.
                if (hold_q[i] == HOLD_MAX) begin
                    if (!fired_q[i]) begin
                        long_d[i]  = 1'b1;
                        fired_d[i] = 1'b1;
                    end
                end else begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fired_q <= '0;
            long_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            fired_q <= fired_d;
            long_q  <= long_d;
            for (int i = 0; i < CHANNELS; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign long_press = long_q;
`else
    assign long_press = '0;
`endif

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench for btn_debounce_multi against a deadline-based reference model.
module tb_btn_debounce_multi;

    localparam int CH = 4;
    localparam int DB = 4;
    localparam int LC = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] raw   = '0;
    logic [CH-1:0] level, press, release_pulse, long_press;
    logic          any_press;

    btn_debounce_multi #(
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .raw          (raw),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .any_press    (any_press),
        .long_press   (long_press)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: raw seen through a 2-edge delay; a mismatch against the
    // debounced level opens a decision deadline DB edges later.
    logic [CH-1:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_long;
    int            m_pend  [CH];
    int            m_pedge [CH];
    int            edge_n = 0;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0;
        m_press = '0; m_rel = '0; m_long = '0;
        for (int i = 0; i < CH; i++) begin
            m_pend[i]  = -1;
            m_pedge[i] = -100000;
        end
    endtask

    task automatic model_edge();
        logic [CH-1:0] rs;
        rs = m_s2;
        m_s2 = m_s1;
        m_s1 = raw;
        m_press = '0; m_rel = '0; m_long = '0;
        for (int i = 0; i < CH; i++) begin
            if (m_pend[i] >= 0) begin
                if (edge_n == m_pend[i]) begin
                    if (rs[i] != m_lvl[i]) begin
                        m_lvl[i] = rs[i];
                        if (rs[i]) begin
                            m_press[i] = 1'b1;
                            m_pedge[i] = edge_n;
                        end else begin
                            m_rel[i] = 1'b1;
                        end
                    end
                    m_pend[i] = -1;
                end
            end else if (rs[i] != m_lvl[i]) begin
                m_pend[i] = edge_n + DB;
            end
`ifdef LONG_PRESS_EN
            if (m_lvl[i] && edge_n == m_pedge[i] + LC) m_long[i] = 1'b1;
`endif
        end
    endtask

    function automatic logic [4*CH:0] exp_vec();
        return {m_lvl, m_press, m_rel, |m_press, m_long};
    endfunction

    function automatic logic [4*CH:0] dut_vec();
        return {level, press, release_pulse, any_press, long_press};
    endfunction

    task automatic step(input logic [CH-1:0] r);
        @(negedge clock);
        raw = r;
        @(posedge clock);
        edge_n++;
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        #1;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 0", dut_vec());
        end
        checks++;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        step('0);
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_first_cycle: got %h expected 0", dut_vec());
        end
        checks++;
    endtask

    task automatic test_clean_press();
        int e0, press_at, long_at, npress, nlong;
        press_at = -1; long_at = -1; npress = 0; nlong = 0;
        repeat (3) step('0);
        step(4'b0001);
        e0 = edge_n;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) step(4'b0001);
            if (press[0]) begin npress++; if (press_at < 0) press_at = edge_n; end
            if (long_press[0]) begin nlong++; if (long_at < 0) long_at = edge_n; end
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL clean_press edge %0d: got %h expected %h", edge_n, dut_vec(), exp_vec());
            end
            checks++;
        end
        if (press_at != e0 + DB + 2 || npress != 1) begin
            errors++;
            $display("FAIL clean_press_latency: got edge %0d count %0d expected edge %0d count 1",
                     press_at - e0, npress, DB + 2);
        end
        checks++;
`ifdef LONG_PRESS_EN
        if (long_at != press_at + LC || nlong != 1) begin
            errors++;
            $display("FAIL long_press: got offset %0d count %0d expected offset %0d count 1",
                     long_at - press_at, nlong, LC);
        end
`else
        if (nlong != 0) begin
            errors++;
            $display("FAIL long_press_off: got count %0d expected 0", nlong);
        end
`endif
        checks++;
        for (int c = 0; c < 12; c++) begin
            step('0);
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL clean_release edge %0d: got %h expected %h", edge_n, dut_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        step(4'b0010);
        step(4'b0010);
        for (int c = 0; c < 12; c++) begin
            step('0);
            seen |= level[1] | press[1] | release_pulse[1];
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL glitch edge %0d: got %h expected %h", edge_n, dut_vec(), exp_vec());
            end
            checks++;
        end
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL glitch_never_asserts: got %b expected 0", seen);
        end
        checks++;
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        int e0, r0, press_at, rel_at, npress, nrel;
        pat = 5'b11101; // applied LSB first: 1,0,1,1,1
        press_at = -1; rel_at = -1; npress = 0; nrel = 0; e0 = 0; r0 = 0;
        for (int c = 0; c < 45; c++) begin
            if (c < 5) step({1'b0, pat[c], 2'b00});
            else if (c < 25) step(4'b0100);
            else step('0);
            if (c == 0) e0 = edge_n;
            if (c == 25) r0 = edge_n;
            if (press[2]) begin npress++; if (press_at < 0) press_at = edge_n; end
            if (release_pulse[2]) begin
                nrel++;
                if (rel_at < 0) rel_at = edge_n;
                if (level[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce_level_on_release: got %b expected 0", level[2]);
                end
                checks++;
            end
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bounce edge %0d: got %h expected %h", edge_n, dut_vec(), exp_vec());
            end
            checks++;
        end
        if (npress != 1 || press_at != e0 + 6 || nrel != 1 || rel_at != r0 + 6) begin
            errors++;
            $display("FAIL bounce_pulses: got press %0d@%0d release %0d@%0d expected 1@6 1@6",
                     npress, press_at - e0, nrel, rel_at - r0);
        end
        checks++;
    endtask

    task automatic test_simultaneous();
        int e0, nany;
        nany = 0;
        step(4'b1111);
        e0 = edge_n;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) step(4'b1111);
            if (any_press) nany++;
            if (edge_n == e0 + 6) begin
                if (press !== 4'b1111 || level !== 4'b1111) begin
                    errors++;
                    $display("FAIL simultaneous_press: got press %b level %b expected 1111 1111",
                             press, level);
                end
                checks++;
            end
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL simultaneous edge %0d: got %h expected %h", edge_n, dut_vec(), exp_vec());
            end
            checks++;
        end
        if (nany != 1) begin
            errors++;
            $display("FAIL simultaneous_any: got %0d pulses expected 1", nany);
        end
        checks++;
        repeat (12) step('0);
        if (level !== 4'b0000) begin
            errors++;
            $display("FAIL simultaneous_release: got level %b expected 0000", level);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        int npress;
        npress = 0;
        repeat (5) step(4'b0001);
        @(negedge clock);
        reset = 1'b1;
        raw = '0;
        #1;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_mid_immediate: got %h expected 0", dut_vec());
        end
        checks++;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            step('0);
            if (press !== '0) npress++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_quiet edge %0d: got %h expected %h", edge_n, dut_vec(), exp_vec());
            end
            checks++;
        end
        for (int c = 0; c < 10; c++) begin
            step(4'b0001);
            if (press[0]) npress++;
        end
        if (npress != 1 || level[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_repress: got %0d presses level %b expected 1 1", npress, level[0]);
        end
        checks++;
        repeat (10) step('0);
    endtask

    task automatic test_random();
        logic [CH-1:0] r;
        int quiet;
        r = '0;
        quiet = 1;
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) quiet = int'($urandom_range(1));
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(quiet ? 39 : 2) == 0) r[i] = ~r[i];
            end
            step(r);
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random edge %0d: got %h expected %h", edge_n, dut_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
